// File: rtl/sp_window_reader_if.sv
//------------------------------------------------------------------------------
// sp_window_reader_if
//
// Bundle of every non-clock, non-reset signal of sp_window_reader.
//
//   Command   : start, base_addr, win_len, stride, num_win
//   Scratchpad: sp_raddr (reader -> scratchpad), sp_dout (scratchpad -> reader,
//               combinational from sp_raddr)
//   Stream    : out_data, out_valid, out_last, out_end (reader -> consumer),
//               out_ready (consumer -> reader)
//   Status    : busy, done
//
// Modports:
//   master - the window reader itself (drives address, stream and status)
//   slave  - the surrounding controller / scratchpad / consumer
//------------------------------------------------------------------------------
interface sp_window_reader_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 4,
   parameter int CNT_WIDTH  = 8
);

   // command
   logic                  start;
   logic [ADDR_WIDTH-1:0] base_addr;
   logic [ADDR_WIDTH:0]   win_len;
   logic [ADDR_WIDTH-1:0] stride;
   logic [CNT_WIDTH-1:0]  num_win;

   // scratchpad read port
   logic [ADDR_WIDTH-1:0] sp_raddr;
   logic [DATA_WIDTH-1:0] sp_dout;

   // output stream
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_valid;
   logic                  out_ready;
   logic                  out_last;
   logic                  out_end;

   // status
   logic                  busy;
   logic                  done;

   modport master (
      input  start, base_addr, win_len, stride, num_win,
      output sp_raddr,
      input  sp_dout,
      output out_data, out_valid, out_last, out_end,
      input  out_ready,
      output busy, done
   );

   modport slave (
      output start, base_addr, win_len, stride, num_win,
      input  sp_raddr,
      output sp_dout,
      input  out_data, out_valid, out_last, out_end,
      output out_ready,
      input  busy, done
   );

endinterface

// File: rtl/sp_window_reader.sv
//------------------------------------------------------------------------------
// sp_window_reader
//
// Read-side sequencer for the register-type scratchpad. A single start pulse
// describes a sequence of num_win sliding windows, each win_len words long,
// starting at base_addr and advancing by stride between windows. The block
// walks the scratchpad addresses (wrapping modulo 2^ADDR_WIDTH), captures the
// combinational read data and streams it to the next PE stage.
//
// Ports:
//   clk       - clock, rising edge
//   rst       - asynchronous, active-low reset
//   bus       - sp_window_reader_if.master (command, scratchpad, stream, status)
//   dbg_state - current FSM state (0 IDLE, 1 RUN, 2 DRAIN, 3 FIN)
//
// Stream handshake: a word transfers on every rising edge where out_valid and
// out_ready are both high. Once out_valid is raised, out_data, out_last and
// out_end stay stable until that transfer happens; out_valid never depends
// combinationally on out_ready.
//------------------------------------------------------------------------------
module sp_window_reader #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 4,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                clk,
   input  logic                rst,
   sp_window_reader_if.master  bus,
   output logic [1:0]          dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_FIN   = 2'd3
   } state_t;

   localparam logic [ADDR_WIDTH:0]  K_ONE = 1;
   localparam logic [CNT_WIDTH-1:0] W_ONE = 1;

   state_t state;
   state_t state_n;

   // latched command
   logic [ADDR_WIDTH:0]   len_r;
   logic [ADDR_WIDTH-1:0] stride_r;
   logic [CNT_WIDTH-1:0]  num_r;

   // walk position: window start address, offset in window, window index
   logic [ADDR_WIDTH-1:0] win_base;
   logic [ADDR_WIDTH:0]   k;
   logic [CNT_WIDTH-1:0]  w;

   // output registers
   logic [DATA_WIDTH-1:0] out_data_r;
   logic                  out_valid_r;
   logic                  out_last_r;
   logic                  out_end_r;

   // strobes from the FSM to the datapath
   logic load;
   logic issue;
   logic drain_clr;

   logic last_k;
   logic last_w;

   // k counts up to win_len-1 only, so equality is enough for "final word".
   assign last_k = (k == len_r - K_ONE);
   assign last_w = (w == num_r - W_ONE);

   //---------------------------------------------------------------------------
   // FSM state register
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_n;
      end
   end

   //---------------------------------------------------------------------------
   // FSM next state and datapath strobes
   //---------------------------------------------------------------------------
   always_comb begin
      state_n   = state;
      load      = 1'b0;
      issue     = 1'b0;
      drain_clr = 1'b0;

      case (state)
         S_IDLE: begin
            if (bus.start) begin
               load = 1'b1;
               // An empty command still passes through FIN so the
               // controller always sees exactly one done pulse.
               if ((bus.win_len == '0) || (bus.num_win == '0)) begin
                  state_n = S_FIN;
               end else begin
                  state_n = S_RUN;
               end
            end
         end

         S_RUN: begin
            // Refill the output register when it is empty or is being
            // consumed on this edge.
            if (!out_valid_r || bus.out_ready) begin
               issue = 1'b1;
               if (last_k && last_w) begin
                  state_n = S_DRAIN;
               end
            end
         end

         S_DRAIN: begin
            if (out_valid_r && bus.out_ready) begin
               drain_clr = 1'b1;
               state_n   = S_FIN;
            end else if (!out_valid_r) begin
               state_n = S_FIN;
            end
         end

         S_FIN: begin
            state_n = S_IDLE;
         end

         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

   //---------------------------------------------------------------------------
   // Datapath: command latch, address walk, output register
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         len_r       <= '0;
         stride_r    <= '0;
         num_r       <= '0;
         win_base    <= '0;
         k           <= '0;
         w           <= '0;
         out_data_r  <= '0;
         out_valid_r <= 1'b0;
         out_last_r  <= 1'b0;
         out_end_r   <= 1'b0;
      end else begin
         if (load) begin
            len_r    <= bus.win_len;
            stride_r <= bus.stride;
            num_r    <= bus.num_win;
            win_base <= bus.base_addr;
            k        <= '0;
            w        <= '0;
         end

         if (issue) begin
            out_data_r  <= bus.sp_dout;
            out_valid_r <= 1'b1;
            out_last_r  <= last_k;
            out_end_r   <= last_k && last_w;
            if (!last_k) begin
               k <= k + K_ONE;
            end else begin
               // Next window; the base address wraps naturally in
               // ADDR_WIDTH bits.
               k        <= '0;
               w        <= w + W_ONE;
               win_base <= win_base + stride_r;
            end
         end

         if (drain_clr) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            out_end_r   <= 1'b0;
         end
      end
   end

   //---------------------------------------------------------------------------
   // Outputs
   //---------------------------------------------------------------------------
   // k stays below 2^ADDR_WIDTH, so dropping its top bit loses nothing; the
   // sum wraps modulo the scratchpad depth. Registers only change outside
   // IDLE (or on the start that leaves IDLE), so the address holds in IDLE.
   assign bus.sp_raddr  = win_base + k[ADDR_WIDTH-1:0];

   assign bus.out_data  = out_data_r;
   assign bus.out_valid = out_valid_r;
   assign bus.out_last  = out_last_r;
   assign bus.out_end   = out_end_r;

   assign bus.busy      = (state != S_IDLE);
   assign bus.done      = (state == S_FIN);

   assign dbg_state     = state;

endmodule
